// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stalls, branch flushes,
// variable-latency data-memory wait states with a timeout fault, and saturating stall/flush counters.
module hazard_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemFault,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, next_state;
  logic [7:0] wait_cnt, next_wait_cnt;
  logic       set_fault;
  logic       branch_flush;
  logic       mem_wait;
  logic       lu;

  assign mem_wait = MemReqM & ~MemReadyM;
  assign lu       = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    next_state    = state;
    next_wait_cnt = wait_cnt;
    set_fault     = 1'b0;
    branch_flush  = 1'b0;
    StallF        = 1'b0;
    StallD        = 1'b0;
    StallE        = 1'b0;
    StallM        = 1'b0;
    FlushD        = 1'b0;
    FlushE        = 1'b0;
    FlushW        = 1'b0;

    case (state)
      RUN: begin
        if (mem_wait) begin
          next_state    = MEMWAIT;
          next_wait_cnt = 8'd1;
        end
      end
      MEMWAIT: begin
        if (mem_wait) begin
          if (wait_cnt == TIMEOUT) begin
            next_state = HALT;
            set_fault  = 1'b1;
          end else begin
            next_wait_cnt = wait_cnt + 8'd1;
          end
        end else begin
          next_state    = RUN;
          next_wait_cnt = 8'd0;
        end
      end
      HALT:    next_state = HALT;
      default: next_state = RUN;
    endcase

    // A branch or load-use seen during a memory wait is simply not acted on; E is held so it re-presents.
    if (state == HALT || mem_wait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (PCSrcE) begin
      FlushD       = 1'b1;
      FlushE       = 1'b1;
      branch_flush = 1'b1;
    end else if (lu) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end

    if (!rst) begin
      StallF       = 1'b0;
      StallD       = 1'b0;
      StallE       = 1'b0;
      StallM       = 1'b0;
      FlushD       = 1'b0;
      FlushE       = 1'b0;
      FlushW       = 1'b0;
      branch_flush = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      wait_cnt   <= 8'd0;
      MemFault   <= 1'b0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait_cnt;
      if (set_fault) MemFault <= 1'b1;
      if (StallF && (StallCount != {CNT_W{1'b1}})) StallCount <= StallCount + 1'b1;
      if (branch_flush && (FlushCount != {CNT_W{1'b1}})) FlushCount <= FlushCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer with a short timeout and narrow counters.
module tb_hazard_sequencer;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  localparam logic [6:0] NONE     = 7'b0000_000;
  localparam logic [6:0] LU       = 7'b1100_010;
  localparam logic [6:0] BR       = 7'b0000_110;
  localparam logic [6:0] MEMSTALL = 7'b1111_001;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       Rs1D, Rs2D, RdE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE, MemReqM, MemReadyM;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault;
  logic [CNT_W-1:0] StallCount, FlushCount;
  logic [6:0]       outs;

  int passed = 0;
  int total  = 0;

  hazard_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemFault(MemFault),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [1:0] rsrc, input logic pc, input logic req, input logic rdy);
    Rs1D = rs1; Rs2D = rs2; RdE = rd; ResultSrcE = rsrc;
    PCSrcE = pc; MemReqM = req; MemReadyM = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with hazard-provoking inputs: outputs must stay quiet
    rst = 1'b0;
    set_in(5'd5, 5'd0, 5'd5, 2'b01, 1'b1, 1'b1, 1'b0);
    #3;
    check("reset_outs", 16'(outs), 16'(NONE));
    check("reset_stallcnt", 16'(StallCount), 16'd0);
    check("reset_flushcnt", 16'(FlushCount), 16'd0);
    check("reset_fault", 16'(MemFault), 16'd0);
    tick();
    rst = 1'b1;
    set_in(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 check("idle", 16'(outs), 16'(NONE));

    // Load-use on Rs1D: one bubble only
    set_in(5'd5, 5'd0, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0);
    #1 check("lu_rs1", 16'(outs), 16'(LU));
    tick();
    set_in(5'd6, 5'd0, 5'd5, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 check("lu_one_bubble", 16'(outs), 16'(NONE));
    check("lu_stallcnt", 16'(StallCount), 16'd1);

    set_in(5'd3, 5'd7, 5'd7, 2'b01, 1'b0, 1'b0, 1'b0);
    #1 check("lu_rs2", 16'(outs), 16'(LU));
    tick();
    check("lu_rs2_stallcnt", 16'(StallCount), 16'd2);

    set_in(5'd7, 5'd7, 5'd7, 2'b10, 1'b0, 1'b0, 1'b0);
    #1 check("not_load", 16'(outs), 16'(NONE));
    set_in(5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    #1 check("lu_x0", 16'(outs), 16'(NONE));

    // Branch beats load-use
    set_in(5'd5, 5'd0, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0);
    #1 check("branch_lu", 16'(outs), 16'(BR));
    tick();
    check("branch_flushcnt", 16'(FlushCount), 16'd1);
    check("branch_stallcnt", 16'(StallCount), 16'd2);

    set_in(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
    #1 check("single_cycle_mem", 16'(outs), 16'(NONE));
    tick();
    check("single_cycle_stallcnt", 16'(StallCount), 16'd2);

    // Asynchronous reset clears counters without a clock edge
    rst = 1'b0;
    #1 check("async_clr_stallcnt", 16'(StallCount), 16'd0);
    check("async_clr_flushcnt", 16'(FlushCount), 16'd0);
    tick();
    rst = 1'b1;

    // Three wait cycles with a deferred branch, then ready
    set_in(5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("memwait_%0d", i), 16'(outs), 16'(MEMSTALL));
      tick();
    end
    MemReadyM = 1'b1;
    #1 check("mem_ready_branch", 16'(outs), 16'(BR));
    check("memwait_stallcnt", 16'(StallCount), 16'd3);
    check("memwait_flushcnt", 16'(FlushCount), 16'd0);
    tick();
    check("deferred_flushcnt", 16'(FlushCount), 16'd1);

    // Wait ended by MemReqM dropping
    set_in(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    #1 check("memwait_again", 16'(outs), 16'(MEMSTALL));
    tick();
    MemReqM = 1'b0;
    #1 check("req_drop", 16'(outs), 16'(NONE));
    tick();
    set_in(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b1);
    #1 check("back_in_run", 16'(outs), 16'(NONE));
    check("req_drop_stallcnt", 16'(StallCount), 16'd4);

    // Timeout: fault rises on the edge ending the 5th wait cycle
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_in(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      #1 check($sformatf("to_stall_%0d", i), 16'(outs), 16'(MEMSTALL));
      check($sformatf("to_nofault_%0d", i), 16'(MemFault), 16'd0);
      tick();
    end
    check("to_fault", 16'(MemFault), 16'd1);
    check("to_stallcnt", 16'(StallCount), 16'd5);
    MemReqM = 1'b0;
    #1 check("halt_stall", 16'(outs), 16'(MEMSTALL));
    tick();
    tick();
    check("halt_stallcnt", 16'(StallCount), 16'd7);
    check("halt_fault_sticky", 16'(MemFault), 16'd1);
    rst = 1'b0;
    #1 check("halt_rst_outs", 16'(outs), 16'(NONE));
    check("halt_rst_fault", 16'(MemFault), 16'd0);
    check("halt_rst_stallcnt", 16'(StallCount), 16'd0);
    tick();
    rst = 1'b1;
    set_in(5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1 check("run_after_halt", 16'(outs), 16'(NONE));

    // Saturation of both counters
    set_in(5'd5, 5'd0, 5'd5, 2'b01, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    check("stallcnt_sat", 16'(StallCount), 16'd15);
    PCSrcE = 1'b1;
    repeat (17) tick();
    check("flushcnt_sat", 16'(FlushCount), 16'd15);
    check("stallcnt_hold", 16'(StallCount), 16'd15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Central pipeline controller for the 5-stage RV32I core.
- Drives stall enables and flush signals for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three conditions:
  - load-use hazards;
  - taken branches/jumps;
  - a variable-latency data-memory handshake in the MEM stage.
- Adds a memory wait-state timeout with a sticky fault, plus saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 16, number of consecutive memory wait cycles tolerated before fault (1..255)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
Rs1D  in  5  source register 1 of the instruction in Decode
Rs2D  in  5  source register 2 of the instruction in Decode
RdE  in  5  destination register of the instruction in Execute
ResultSrcE  in  2  result select in Execute; 2'b01 = load
PCSrcE  in  1  branch/jump taken, resolved in Execute
MemReqM  in  1  load/store present in Memory stage
MemReadyM  in  1  data memory completes access this cycle
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
StallM  out  1  hold EX/MEM register
FlushD  out  1  clear IF/ID to bubble
FlushE  out  1  clear ID/EX to bubble
FlushW  out  1  load bubble into MEM/WB (RegWriteW=0)
MemFault  out  1  sticky timeout fault
StallCount  out  CNT_W  cycles with StallF=1, saturating
FlushCount  out  CNT_W  cycles with PCSrcE-caused flush, saturating

Behaviour:

Reset (rst=0, asynchronous):
- state=RUN, wait counter=0, MemFault=0, StallCount=0, FlushCount=0.
- All Stall*/Flush* outputs are 0 while rst=0.

Definitions:
- mem_wait = MemReqM & ~MemReadyM.
- lu = (ResultSrcE==2'b01) & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D)).

States: RUN, MEMWAIT, HALT. State and counters are registered; control outputs are combinational from state and current inputs (zero latency).

Output priority, highest first:
1. HALT:
   - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
2. mem_wait in RUN or MEMWAIT:
   - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
   - A PCSrcE or lu present in the same cycle is deferred: E is held, so it re-presents after the wait.
3. PCSrcE=1:
   - FlushD=1, FlushE=1, no stalls.
   - Branch beats a simultaneous lu, because the dependent instruction is squashed.
4. lu:
   - StallF=1, StallD=1, FlushE=1.
   - Exactly one bubble per load-use pair, because the load leaves E on the next edge.
5. Otherwise all outputs are 0.

Transitions:
- RUN → MEMWAIT when mem_wait; wait counter ← 1.
- MEMWAIT, mem_wait:
  - If counter==MEM_TIMEOUT: → HALT, MemFault←1.
  - Else counter+1.
- MEMWAIT, ~mem_wait (ready arrives, or MemReqM drops): → RUN, counter←0. No stall in that cycle.
- HALT: stays until rst=0. MemFault remains 1.

Counters:
- StallCount increments on every edge where StallF=1 (including HALT).
- FlushCount increments on edges where priority 3 is active.
- Both saturate at all-ones.

Other rules:
- Rs fields equal to x0 never cause an lu hazard.
- A single-cycle access (MemReqM=1, MemReadyM=1) causes no stall.
- Reset asserted mid-wait or in HALT returns to RUN immediately, with counters cleared.

Test Plan:
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5 for one cycle → StallF=StallD=FlushE=1 for that cycle only; StallCount=1.
- Load-use on x0: RdE=0, Rs2D=0, ResultSrcE=01 → all outputs 0.
- Branch plus load-use: PCSrcE=1 together with lu → FlushD=FlushE=1, StallF=0; FlushCount increments by 1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then ready → StallF..StallM=1 and FlushW=1 for exactly 3 cycles, state returns to RUN, StallCount=3.
- Timeout: MEM_TIMEOUT=4, MemReadyM held at 0 → MemFault rises at the edge ending the 5th wait cycle; stalls remain after MemReqM drops, until rst=0 clears everything asynchronously.
- Saturation: CNT_W=4, 20 stall cycles → StallCount=15.
